// File: rtl/histograma_latencia.sv
// One-hot bucket to latency-bin encoder with per-bin event counters, read port and background clear.
// Optional macro HISTOGRAMA_LATENCIA_SAT_EN makes the counters saturate instead of wrapping.
module histograma_latencia #(
  parameter int NUM_BUCKETS = 14,
  parameter int BITS_SHIFT  = 7,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   index_valid,
  input  logic [NUM_BUCKETS-1:0] index,
  output logic                   latencia_valid,
  output logic [BITS_SHIFT-1:0]  latencia,
  output logic                   erro,
  input  logic                   rd_req,
  input  logic [BITS_SHIFT-1:0]  rd_addr,
  output logic                   rd_ack,
  output logic [CNT_WIDTH-1:0]   rd_data,
  input  logic                   clear,
  output logic                   busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // The invalid counter lives just past the last bin, at address NUM_BUCKETS.
  localparam logic [BITS_SHIFT-1:0] INV_ADDR = BITS_SHIFT'(NUM_BUCKETS);

  state_t                 state_q, state_d;
  logic [BITS_SHIFT-1:0]  ptr;
  logic [CNT_WIDTH-1:0]   cnt [NUM_BUCKETS+1];
  logic [BITS_SHIFT-1:0]  enc_lat;
  logic                   enc_err;
  logic                   hit, multi;
  logic [BITS_SHIFT-1:0]  inc_addr;
  logic                   inc_en;
  logic [CNT_WIDTH-1:0]   rd_sel;

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c);
`ifdef HISTOGRAMA_LATENCIA_SAT_EN
    bump = (c == {CNT_WIDTH{1'b1}}) ? c : c + CNT_WIDTH'(1);
`else
    bump = c + CNT_WIDTH'(1);
`endif
  endfunction

  // Ascending scan so the highest set bit is the last one to claim enc_lat.
  always_comb begin
    enc_lat = '1;
    hit     = 1'b0;
    multi   = 1'b0;
    for (int i = 0; i < NUM_BUCKETS; i++) begin
      if (index[i]) begin
        multi   = multi | hit;
        hit     = 1'b1;
        enc_lat = BITS_SHIFT'(NUM_BUCKETS - 1 - i);
      end
    end
    enc_err = ~hit | multi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latencia_valid <= 1'b0;
      latencia       <= '1;
      erro           <= 1'b0;
    end else begin
      latencia_valid <= index_valid;
      erro           <= index_valid & enc_err;
      if (index_valid) latencia <= enc_lat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear) state_d = CLEAR;
      CLEAR:   if (ptr == INV_ADDR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign inc_en   = latencia_valid & ~busy;
  assign inc_addr = erro ? INV_ADDR : latencia;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   ptr <= '0;
    else if (busy)  ptr <= ptr + BITS_SHIFT'(1);
    else            ptr <= '0;
  end

  // The sweep wins over increments; increments are also gated off for the whole sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= NUM_BUCKETS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i <= NUM_BUCKETS; i++) begin
        if (busy && ptr == BITS_SHIFT'(i))
          cnt[i] <= '0;
        else if (inc_en && inc_addr == BITS_SHIFT'(i))
          cnt[i] <= bump(cnt[i]);
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= NUM_BUCKETS; i++)
      if (rd_addr == BITS_SHIFT'(i)) rd_sel = cnt[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_req & ~busy;
      if (rd_req && !busy) rd_data <= rd_sel;
    end
  end

endmodule

// File: tb/tb_histograma_latencia.sv
// Directed bench for histograma_latencia: a count-based model checked every cycle, plus literal spot checks.
// A second instance with CNT_WIDTH=4 shares the stimulus to exercise wrap/saturation.
module tb_histograma_latencia;

  localparam int NB = 14;
  localparam int BS = 7;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          index_valid = 1'b0;
  logic [NB-1:0] index = '0;
  logic          rd_req = 1'b0;
  logic [BS-1:0] rd_addr = '0;
  logic          clear = 1'b0;

  logic          latencia_valid, erro, rd_ack, busy;
  logic [BS-1:0] latencia;
  logic [CW-1:0] rd_data;

  logic          latencia_valid4, erro4, rd_ack4, busy4;
  logic [BS-1:0] latencia4;
  logic [3:0]    rd_data4;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  histograma_latencia #(.NUM_BUCKETS(NB), .BITS_SHIFT(BS), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .index_valid(index_valid), .index(index),
    .latencia_valid(latencia_valid), .latencia(latencia), .erro(erro),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .clear(clear), .busy(busy)
  );

  histograma_latencia #(.NUM_BUCKETS(NB), .BITS_SHIFT(BS), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .index_valid(index_valid), .index(index),
    .latencia_valid(latencia_valid4), .latencia(latencia4), .erro(erro4),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack4), .rd_data(rd_data4),
    .clear(clear), .busy(busy4)
  );

  always #5 clk = ~clk;

  // Model: true event counts per bin; each DUT width sees them folded by wrap or saturation.
  longint        m_cnt [NB+1];
  longint        m_data;
  logic          m_lv, m_err, m_ack;
  logic [BS-1:0] m_lat;
  int            busy_left;
  logic          busy_now;
  int            hi;

  function automatic longint fold(input longint n, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
`ifdef HISTOGRAMA_LATENCIA_SAT_EN
    return (n > mx) ? mx : n;
`else
    return n & mx;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lv = 1'b0; m_err = 1'b0; m_lat = '1; m_ack = 1'b0; m_data = 0; busy_left = 0;
      for (int i = 0; i <= NB; i++) m_cnt[i] = 0;
    end else begin
      busy_now = (busy_left > 0);
      m_ack = rd_req && !busy_now;
      if (m_ack) m_data = (int'(rd_addr) <= NB) ? m_cnt[rd_addr] : 0;
      if (m_lv && !busy_now) m_cnt[m_err ? NB : int'(m_lat)]++;
      if (busy_now) busy_left--;
      else if (clear) begin
        busy_left = NB + 1;
        for (int i = 0; i <= NB; i++) m_cnt[i] = 0;
      end
      m_lv = index_valid;
      if (index_valid) begin
        hi = -1;
        for (int k = 0; k < NB; k++) if (index[k]) hi = k;
        if (hi < 0) begin m_lat = '1; m_err = 1'b1; end
        else begin m_lat = BS'(NB - 1 - hi); m_err = ($countones(index) != 1); end
      end else m_err = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("latencia_valid", 64'(latencia_valid), 64'(m_lv));
      checkOutput("latencia", 64'(latencia), 64'(m_lat));
      checkOutput("erro", 64'(erro), 64'(m_err));
      checkOutput("busy", 64'(busy), 64'(busy_left > 0));
      checkOutput("rd_ack", 64'(rd_ack), 64'(m_ack));
      checkOutput("rd_ack_w4", 64'(rd_ack4), 64'(m_ack));
      if (m_ack) begin
        checkOutput("rd_data", 64'(rd_data), 64'(fold(m_data, CW)));
        checkOutput("rd_data_w4", 64'(rd_data4), 64'(fold(m_data, 4)));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [NB-1:0] idx);
    @(posedge clk); #1;
    index_valid = v;
    index = idx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
  endtask

  task automatic readBin(input int a, input longint expv, input string nm);
    @(posedge clk); #1;
    index_valid = 1'b0;
    rd_req = 1'b1;
    rd_addr = BS'(a);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    checkOutput({nm, "_ack"}, 64'(rd_ack), 64'd1);
    checkOutput(nm, 64'(rd_data), 64'(expv));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NB-1:0] vecs[3];
    int            lats[3];
    int            nbusy;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_latencia", 64'(latencia), 64'h7F);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    for (int a = 0; a <= NB; a++) readBin(a, 0, "reset_read");
    readBin(NB + 1, 0, "out_of_range_read");

    vecs = '{14'h0001, 14'h2000, 14'h0004};
    lats = '{13, 0, 11};
    for (int j = 0; j <= 3; j++) begin
      if (j < 3) applyStimulus(1'b1, vecs[j]); else applyStimulus(1'b0, '0);
      @(negedge clk);
      if (j > 0) begin
        checkOutput("onehot_lat", 64'(latencia), 64'(lats[j-1]));
        checkOutput("onehot_erro", 64'(erro), 64'd0);
      end
    end
    idle(2);
    readBin(13, 1, "bin13");
    readBin(0, 1, "bin0");
    readBin(11, 1, "bin11");

    vecs = '{14'h0000, 14'h0081, 14'h0000};
    lats = '{127, 6, 0};
    for (int j = 0; j <= 2; j++) begin
      if (j < 2) applyStimulus(1'b1, vecs[j]); else applyStimulus(1'b0, '0);
      @(negedge clk);
      if (j > 0) begin
        checkOutput("bad_lat", 64'(latencia), 64'(lats[j-1]));
        checkOutput("bad_erro", 64'(erro), 64'd1);
      end
    end
    idle(2);
    readBin(NB, 2, "invalid_cnt");
    readBin(6, 0, "bin6_untouched");

    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      index_valid = 1'b1;
      index = 14'h0010;
      rd_req = (i == 40);
      rd_addr = 7'd9;
      if (i == 41) begin
        @(negedge clk);
        checkOutput("stream_read_ack", 64'(rd_ack), 64'd1);
        checkOutput("stream_read", 64'(rd_data), 64'd39);
      end
    end
    idle(3);
    readBin(9, 100, "stream_final");

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 14'h0010);
    @(posedge clk); #1;
    clear = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      clear = (i == 3);
      rd_req = (i == 5);
      rd_addr = 7'd9;
      index_valid = (i < 10);
      index = 14'h0010;
      @(negedge clk);
      if (busy) nbusy++;
      if (i == 6) checkOutput("busy_read_noack", 64'(rd_ack), 64'd0);
    end
    checkOutput("busy_cycles", 64'(nbusy), 64'd15);
    readBin(9, 0, "bin9_after_clear");
    readBin(NB, 0, "invalid_after_clear");

    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 14'h0800);
    idle(3);
    readBin(2, 17, "bin2_w32");
`ifdef HISTOGRAMA_LATENCIA_SAT_EN
    checkOutput("bin2_w4", 64'(rd_data4), 64'd15);
`else
    checkOutput("bin2_w4", 64'(rd_data4), 64'd1);
`endif

    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    idle(3);
    chk_en = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midclear_reset_busy", 64'(busy), 64'd0);
    checkOutput("midclear_reset_lat", 64'(latencia), 64'h7F);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    idle(2);
    readBin(2, 0, "bin2_after_reset");

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/histograma_latencia.md
Name: histograma_latencia

Overview:
- Parametrised successor to the one-hot bucket-to-latency decoder.
- Accepts a registered stream of one-hot bucket vectors and encodes each into a latency bin: bin = NUM_BUCKETS-1-bitpos.
- Keeps one event counter per bin, plus a count of invalid vectors.
- Counters are readable through a simple request/ack port and can be cleared in the background. Sits after the hash/bucket stage, feeding the statistics register block.

Parameters:
- NUM_BUCKETS, 14, width of the one-hot index and number of histogram bins (2..64).
- BITS_SHIFT, 7, width of the latency/bin code; must satisfy 2**BITS_SHIFT > NUM_BUCKETS.
- CNT_WIDTH, 32, width of each bin counter and of the invalid counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- index_valid  in  1  index is valid this cycle.
- index  in  NUM_BUCKETS  one-hot bucket vector.
- latencia_valid  out  1  encoded bin valid, one cycle after index_valid.
- latencia  out  BITS_SHIFT  encoded bin.
- erro  out  1  pulses with latencia_valid when the index was zero or multi-hot.
- rd_req  in  1  counter read request; single-cycle pulse.
- rd_addr  in  BITS_SHIFT  bin to read; the value NUM_BUCKETS selects the invalid counter.
- rd_ack  out  1  read data valid; single-cycle pulse.
- rd_data  out  CNT_WIDTH  counter value.
- clear  in  1  start clearing all counters; single-cycle pulse.
- busy  out  1  clear in progress.

Behaviour:
- Reset: all counters = 0; latencia = all-ones; latencia_valid, erro, rd_ack, busy = 0; rd_data = 0; FSM = IDLE.
- Reset mid-clear or mid-read aborts immediately; no partial state survives.

Stage 1 (encode, latency 1 cycle):
- Exactly one bit k set: latencia = NUM_BUCKETS-1-k, erro = 0.
- index == 0: latencia = all-ones, erro = 1.
- Multi-hot: the highest set bit k wins, latencia = NUM_BUCKETS-1-k, erro = 1.
- latencia_valid = registered index_valid. When index_valid = 0, latencia holds its last value.

Stage 2 (count, 1 cycle after stage 1):
- latencia_valid with erro = 0: counter[latencia] increments by 1.
- erro = 1: the invalid counter increments instead; no bin counter changes.
- Back-to-back events to the same bin, every cycle, must all be counted with no loss.
- Counters wrap modulo 2**CNT_WIDTH, unless the optional feature below is enabled.

Read:
- rd_req in cycle N gives rd_ack and rd_data in cycle N+1.
- rd_data is the counter value at the start of cycle N; an increment landing in cycle N is not included.
- rd_addr > NUM_BUCKETS returns 0 and still acks.
- rd_req while busy = 1 is ignored (no ack); the master must wait for busy = 0.

FSM states: IDLE, CLEAR.
- IDLE to CLEAR on clear = 1; busy rises the next cycle.
- CLEAR zeroes one counter per cycle (bin 0..NUM_BUCKETS-1, then the invalid counter), i.e. NUM_BUCKETS+1 cycles.
- After the last counter, CLEAR returns to IDLE and busy falls.
- During CLEAR, stage-2 increments are dropped. Stage 1 keeps running, so latencia_valid and erro stay live.
- clear asserted while already busy is ignored; the sweep is not restarted.

Optional Feature:
- Macro: HISTOGRAMA_LATENCIA_SAT_EN.
- Defined: every counter saturates at 2**CNT_WIDTH-1 and further increments leave it unchanged.
- Undefined: counters wrap to 0.
- Stage 1, read and clear behaviour are identical in both builds.

Test Plan:
- Reset, then read bins 0..14 -> each read gives rd_ack one cycle later with rd_data = 0; latencia = 7'h7F, busy = 0.
- index = 14'h0001, 14'h2000, 14'h0004 on consecutive cycles -> latencia = 13, 0, 11 with erro = 0; then read bin 13 = 1, bin 0 = 1, bin 11 = 1.
- index = 0, then 14'h0081 -> latencia = 7'h7F with erro = 1, then latencia = 6 with erro = 1; invalid counter (rd_addr = 14) = 2; all bin counters remain 0.
- 100 consecutive cycles of index = 14'h0010 with rd_req for bin 9 issued during the stream -> rd_data equals the events counted before the request cycle; the final read gives 100.
- After 5 events in bin 9, assert clear -> busy high for 15 cycles; rd_req during busy gets no ack; events during busy are not counted; reading bin 9 afterwards gives 0.
- CNT_WIDTH = 4, 17 events to bin 2 -> HISTOGRAMA_LATENCIA_SAT_EN defined reads 15, undefined reads 1.
